// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one combinational multiplier between NUM_REQ requesters.
// Each operation is accept -> issue (operands registered) -> response handshake.
module mul_sched #(
    parameter int BITWIDTH = 32,
    parameter int NUM_REQ  = 4,
    parameter int CNT_W    = 16,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_ain,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_bin,
    output logic [BITWIDTH-1:0]          mul_ain,
    output logic [BITWIDTH-1:0]          mul_bin,
    input  logic [BITWIDTH-1:0]          mul_dout,
    input  logic                         mul_overflow,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [BITWIDTH-1:0]          rsp_dout,
    output logic                         rsp_overflow,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy,
    output logic [CNT_W-1:0]             op_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                state_q,        state_d;
    logic [ID_W-1:0]       ptr_q,          ptr_d;
    logic [ID_W-1:0]       grant_id_q,     grant_id_d;
    logic [BITWIDTH-1:0]   mul_ain_q,      mul_ain_d;
    logic [BITWIDTH-1:0]   mul_bin_q,      mul_bin_d;
    logic [BITWIDTH-1:0]   rsp_dout_q,     rsp_dout_d;
    logic                  rsp_overflow_q, rsp_overflow_d;
    logic [CNT_W-1:0]      op_count_q,     op_count_d;

    logic                  win_found;
    int                    win;
    logic [ID_W-1:0]       win_id;

    // Rotating priority: scan offsets high to low so the smallest offset from ptr wins.
    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        win_found = 1'b0;
        win       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win       = (int'(ptr_q) + k) % NUM_REQ;
            end
        end
        win_id = ID_W'(win);
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_id_d     = grant_id_q;
        mul_ain_d      = mul_ain_q;
        mul_bin_d      = mul_bin_q;
        rsp_dout_d     = rsp_dout_q;
        rsp_overflow_d = rsp_overflow_q;
        op_count_d     = op_count_q;
        req_ready      = '0;
        rsp_valid      = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready[win_id] = 1'b1;
                    mul_ain_d         = req_ain[win*BITWIDTH +: BITWIDTH];
                    mul_bin_d         = req_bin[win*BITWIDTH +: BITWIDTH];
                    grant_id_d        = win_id;
                    ptr_d             = ID_W'((win + 1) % NUM_REQ);
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Operands have been stable on the multiplier for a full cycle.
                rsp_dout_d     = mul_dout;
                rsp_overflow_d = mul_overflow;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[grant_id_q] = 1'b1;
                if (rsp_ready[grant_id_q]) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: every register here is plain state (no memory arrays), so all of it is reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            grant_id_q     <= '0;
            mul_ain_q      <= '0;
            mul_bin_q      <= '0;
            rsp_dout_q     <= '0;
            rsp_overflow_q <= 1'b0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_id_q     <= grant_id_d;
            mul_ain_q      <= mul_ain_d;
            mul_bin_q      <= mul_bin_d;
            rsp_dout_q     <= rsp_dout_d;
            rsp_overflow_q <= rsp_overflow_d;
            op_count_q     <= op_count_d;
        end
    end

    assign mul_ain      = mul_ain_q;
    assign mul_bin      = mul_bin_q;
    assign rsp_dout     = rsp_dout_q;
    assign rsp_overflow = rsp_overflow_q;
    assign grant_id     = grant_id_q;
    assign op_count     = op_count_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched; a behavioural 32x32 multiplier sits on the mul_* ports.
module tb_mul_sched;

    localparam int BW = 32;
    localparam int NR = 4;
    localparam int CW = 16;

    logic              clk;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*BW-1:0]  req_ain;
    logic [NR*BW-1:0]  req_bin;
    logic [BW-1:0]     mul_ain;
    logic [BW-1:0]     mul_bin;
    logic [BW-1:0]     mul_dout;
    logic              mul_overflow;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [BW-1:0]     rsp_dout;
    logic              rsp_overflow;
    logic [1:0]        grant_id;
    logic              busy;
    logic [CW-1:0]     op_count;

    logic [63:0]       full_prod;

    int n_pass;
    int n_total;

    mul_sched #(.BITWIDTH(BW), .NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_ain      (req_ain),
        .req_bin      (req_bin),
        .mul_ain      (mul_ain),
        .mul_bin      (mul_bin),
        .mul_dout     (mul_dout),
        .mul_overflow (mul_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_dout     (rsp_dout),
        .rsp_overflow (rsp_overflow),
        .grant_id     (grant_id),
        .busy         (busy),
        .op_count     (op_count)
    );

    assign full_prod    = {32'd0, mul_ain} * {32'd0, mul_bin};
    assign mul_dout     = full_prod[31:0];
    assign mul_overflow = |full_prod[63:32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
        req_ain[i*BW +: BW] = a;
        req_bin[i*BW +: BW] = b;
    endtask

    initial begin
        logic [BW-1:0] exp_dout [4];
        n_pass    = 0;
        n_total   = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_ain   = '0;
        req_bin   = '0;
        exp_dout  = '{32'd2, 32'd4, 32'd6, 32'd8};

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 4'b0000);
        check("rst_mul_ain", mul_ain, 0);
        check("rst_rsp_dout", rsp_dout, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        check("rst_grant_id", grant_id, 0);
        reset_n = 1'b1;
        tick();

        // Single request: 3*5
        set_req(0, 32'd3, 32'd5);
        req_valid = 4'b0001;
        #1;
        check("single_req_ready", req_ready, 4'b0001);
        check("single_busy_idle", busy, 0);
        tick();
        req_valid = '0;
        check("single_issue_busy", busy, 1);
        check("single_issue_ready", req_ready, 4'b0000);
        check("single_mul_ain", mul_ain, 3);
        check("single_mul_bin", mul_bin, 5);
        check("single_issue_rsp_valid", rsp_valid, 4'b0000);
        tick();
        check("single_rsp_valid", rsp_valid, 4'b0001);
        check("single_rsp_dout", rsp_dout, 32'h0000000F);
        check("single_rsp_ovf", rsp_overflow, 0);
        rsp_ready = 4'b0001;
        tick();
        check("single_op_count", op_count, 1);
        check("single_idle_busy", busy, 0);
        check("single_idle_rsp_valid", rsp_valid, 4'b0000);
        check("single_persist_ain", mul_ain, 3);

        // Overflow on requester 2 (ptr=1)
        rsp_ready = 4'b1111;
        set_req(2, 32'h00010000, 32'h00010000);
        req_valid = 4'b0100;
        #1;
        check("ovf_req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        check("ovf_rsp_valid", rsp_valid, 4'b0100);
        check("ovf_rsp_dout", rsp_dout, 0);
        check("ovf_rsp_ovf", rsp_overflow, 1);
        check("ovf_grant_id", grant_id, 2);
        tick();
        check("ovf_op_count", op_count, 2);

        // Wrap-around: ptr=3, req1 and req3 together -> 3 first
        set_req(1, 32'h10, 32'h10);
        set_req(3, 32'd6, 32'd7);
        req_valid = 4'b1010;
        #1;
        check("wrap_first_ready", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0010;
        tick();
        check("wrap_first_rsp", rsp_valid, 4'b1000);
        check("wrap_first_dout", rsp_dout, 32'h2A);
        tick();
        check("wrap_second_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        tick();
        check("wrap_second_rsp", rsp_valid, 4'b0010);
        check("wrap_second_dout", rsp_dout, 32'h100);
        check("wrap_second_grant", grant_id, 1);
        tick();
        check("wrap_op_count", op_count, 4);

        // Back-pressure on requester 0 (ptr=2); other rsp_ready lines must be ignored
        rsp_ready = 4'b1110;
        set_req(0, 32'd7, 32'd9);
        req_valid = 4'b0001;
        #1;
        check("bp_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0010;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", rsp_valid, 4'b0001);
            check("bp_rsp_dout", rsp_dout, 63);
            check("bp_req_ready_hold", req_ready, 4'b0000);
            check("bp_busy", busy, 1);
            tick();
        end
        check("bp_still_held", rsp_valid, 4'b0001);
        check("bp_count_held", op_count, 4);
        req_valid = '0;
        rsp_ready = 4'b0001;
        tick();
        check("bp_done_busy", busy, 0);
        check("bp_done_count", op_count, 5);

        // Reset mid-ISSUE (ptr=1, req3 wins)
        set_req(3, 32'd4, 32'd4);
        req_valid = 4'b1000;
        #1;
        check("rmid_req_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        check("rmid_issue_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rmid_busy", busy, 0);
        check("rmid_mul_ain", mul_ain, 0);
        check("rmid_grant_id", grant_id, 0);
        check("rmid_op_count", op_count, 0);
        check("rmid_rsp_valid", rsp_valid, 4'b0000);
        check("rmid_req_ready", req_ready, 4'b0000);

        // Contention: all four valid with ain=i+1, bin=2; served 0,1,2,3 from ptr=0
        for (int i = 0; i < NR; i++) set_req(i, BW'(i + 1), 32'd2);
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < NR; i++) begin
            check("cont_req_ready", req_ready, 4'b0001 << i);
            tick();
            req_valid[i] = 1'b0;
            check("cont_issue_rsp_valid", rsp_valid, 4'b0000);
            tick();
            check("cont_rsp_valid", rsp_valid, 4'b0001 << i);
            check("cont_rsp_dout", rsp_dout, exp_dout[i]);
            check("cont_grant_id", grant_id, i);
            tick();
        end
        check("cont_op_count", op_count, 4);
        check("cont_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
